// File: rtl/darkbus_arbiter_if.sv
// darkbus port bundle: one request/response channel.
// master drives the request, slave returns data and completion.
interface darkbus_arbiter_if;
    logic        en;
    logic        rw;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        valid;
    logic        err;

    modport master (
        output en, rw, be, addr, wdata,
        input  rdata, valid
    );

    modport slave (
        input  en, rw, be, addr, wdata,
        output rdata, valid, err
    );
endinterface

// File: rtl/darkbus_arbiter.sv
// Two-master round-robin arbiter for the darkbus memory port,
// one outstanding transaction, registered response, timeout error.
module darkbus_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 16
) (
    input  logic             clk,
    input  logic             res,
    darkbus_arbiter_if.slave  m0,
    darkbus_arbiter_if.slave  m1,
    darkbus_arbiter_if.master s
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    state_t        state;
    logic          grant;
    logic          last;
    logic [CW-1:0] cnt;
    logic          valid0;
    logic          valid1;
    logic          err0;
    logic          err1;
    logic [31:0]   rdata0;
    logic [31:0]   rdata1;
    logic          busy;
    logic          done;

    assign busy = (state == BUSY);
    assign done = s.valid || (cnt == LAST_CNT);

    always_comb begin
        s.en    = busy;
        s.rw    = 1'b0;
        s.be    = '0;
        s.addr  = '0;
        s.wdata = '0;
        if (busy) begin
            if (grant) begin
                s.rw    = m1.rw;
                s.be    = m1.be;
                s.addr  = m1.addr;
                s.wdata = m1.wdata;
            end else begin
                s.rw    = m0.rw;
                s.be    = m0.be;
                s.addr  = m0.addr;
                s.wdata = m0.wdata;
            end
        end
    end

    assign m0.valid = valid0;
    assign m0.err   = err0;
    assign m0.rdata = rdata0;
    assign m1.valid = valid1;
    assign m1.err   = err1;
    assign m1.rdata = rdata1;

    always_ff @(posedge clk) begin
        if (!res) begin
            state  <= IDLE;
            grant  <= 1'b0;
            last   <= 1'b1;
            cnt    <= '0;
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (m0.en || m1.en) begin
                        // tie goes to whoever was not served last
                        grant <= (m0.en && m1.en) ? ~last : m1.en;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (done) begin
                        last  <= grant;
                        cnt   <= '0;
                        state <= RESP;
                        if (grant) begin
                            valid1 <= 1'b1;
                            err1   <= ~s.valid;
                            if (!s.valid)
                                rdata1 <= '0;
                            else if (!s.rw)
                                rdata1 <= s.rdata;
                        end else begin
                            valid0 <= 1'b1;
                            err0   <= ~s.valid;
                            if (!s.valid)
                                rdata0 <= '0;
                            else if (!s.rw)
                                rdata0 <= s.rdata;
                        end
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_darkbus_arbiter.sv
// Directed bench for darkbus_arbiter: per-cycle vector table
// plus hand sequences for timeout, reset and dropped requests.
module tb_darkbus_arbiter;
    localparam int TO = 4;

    typedef struct packed {
        logic        en;
        logic        rw;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        req_t        m0;
        req_t        m1;
        logic        sv;
        logic [31:0] sd;
        req_t        s;
        resp_t       r0;
        resp_t       r1;
    } vec_t;

    logic clk = 1'b0;
    logic res = 1'b0;
    int   tests = 0;
    int   fails = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    darkbus_arbiter_if m0_bus ();
    darkbus_arbiter_if m1_bus ();
    darkbus_arbiter_if s_bus ();

    darkbus_arbiter #(.TIMEOUT(TO), .CW(4)) dut (
        .clk(clk),
        .res(res),
        .m0 (m0_bus),
        .m1 (m1_bus),
        .s  (s_bus)
    );

    localparam req_t  NR = '0;
    localparam resp_t NZ = '0;

    function automatic req_t rd(logic [31:0] a);
        return {1'b1, 1'b0, 4'hF, a, 32'h0};
    endfunction

    function automatic req_t wr(logic [31:0] a, logic [3:0] b,
                                logic [31:0] d);
        return {1'b1, 1'b1, b, a, d};
    endfunction

    function automatic resp_t rs(logic v, logic e, logic [31:0] d);
        return {v, e, d};
    endfunction

    function automatic req_t sbus();
        return {s_bus.en, s_bus.rw, s_bus.be, s_bus.addr, s_bus.wdata};
    endfunction

    function automatic resp_t r0bus();
        return {m0_bus.valid, m0_bus.err, m0_bus.rdata};
    endfunction

    function automatic resp_t r1bus();
        return {m1_bus.valid, m1_bus.err, m1_bus.rdata};
    endfunction

    task automatic chk(string nm, logic [69:0] act, logic [69:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_m0(req_t r);
        m0_bus.en    = r.en;
        m0_bus.rw    = r.rw;
        m0_bus.be    = r.be;
        m0_bus.addr  = r.addr;
        m0_bus.wdata = r.wdata;
    endtask

    task automatic set_m1(req_t r);
        m1_bus.en    = r.en;
        m1_bus.rw    = r.rw;
        m1_bus.be    = r.be;
        m1_bus.addr  = r.addr;
        m1_bus.wdata = r.wdata;
    endtask

    task automatic set_s(logic v, logic [31:0] d);
        s_bus.valid = v;
        s_bus.rdata = d;
    endtask

    task automatic add(req_t a, req_t b, logic sv, logic [31:0] sd,
                       req_t s, resp_t r0, resp_t r1);
        vec_t v;
        v.m0 = a;
        v.m1 = b;
        v.sv = sv;
        v.sd = sd;
        v.s  = s;
        v.r0 = r0;
        v.r1 = r1;
        vq.push_back(v);
    endtask

    initial begin
        req_t a, b, r, w;
        logic [31:0] d0, d1, d2, d3, cf;
        int n;
        bit got;

        a  = rd(32'h10);
        b  = rd(32'h20);
        r  = rd(32'h100);
        w  = wr(32'h204, 4'b0011, 32'h1234_5678);
        d0 = 32'hA0A0_0000;
        d1 = 32'hA1A1_0001;
        d2 = 32'hA2A2_0002;
        d3 = 32'hA3A3_0003;
        cf = 32'hCAFE_F00D;

        // continuous contention: m0, m1, m0, m1
        add(a, b, 0, 0,  NR, NZ, NZ);
        add(a, b, 1, d0, a,  NZ, NZ);
        add(a, b, 0, 0,  NR, rs(1, 0, d0), NZ);
        add(a, b, 0, 0,  NR, rs(0, 0, d0), NZ);
        add(a, b, 1, d1, b,  rs(0, 0, d0), NZ);
        add(a, b, 0, 0,  NR, rs(0, 0, d0), rs(1, 0, d1));
        add(a, b, 0, 0,  NR, rs(0, 0, d0), rs(0, 0, d1));
        add(a, b, 1, d2, a,  rs(0, 0, d0), rs(0, 0, d1));
        add(a, b, 0, 0,  NR, rs(1, 0, d2), rs(0, 0, d1));
        add(a, b, 0, 0,  NR, rs(0, 0, d2), rs(0, 0, d1));
        add(a, b, 1, d3, b,  rs(0, 0, d2), rs(0, 0, d1));
        add(NR, NR, 0, 0, NR, rs(0, 0, d2), rs(1, 0, d3));
        // m0 read of 0x100
        add(r, NR, 0, 0,  NR, rs(0, 0, d2), rs(0, 0, d3));
        add(r, NR, 1, cf, r,  rs(0, 0, d2), rs(0, 0, d3));
        add(NR, NR, 0, 0, NR, rs(1, 0, cf), rs(0, 0, d3));
        add(NR, NR, 0, 0, NR, rs(0, 0, cf), rs(0, 0, d3));
        // m1 write: read data must not change
        add(NR, w, 0, 0, NR, rs(0, 0, cf), rs(0, 0, d3));
        add(NR, w, 1, 32'hDEAD_BEEF, w, rs(0, 0, cf), rs(0, 0, d3));
        add(NR, NR, 0, 0, NR, rs(0, 0, cf), rs(1, 0, d3));
        add(NR, NR, 0, 0, NR, rs(0, 0, cf), rs(0, 0, d3));

        set_m0(NR);
        set_m1(NR);
        set_s(0, 0);
        s_bus.err = 1'b0;
        res = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s", 70'(sbus()), 70'(NR));
        chk("rst_r0", 70'(r0bus()), 70'(NZ));
        chk("rst_r1", 70'(r1bus()), 70'(NZ));
        res = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            set_m0(vq[i].m0);
            set_m1(vq[i].m1);
            set_s(vq[i].sv, vq[i].sd);
            #1;
            chk($sformatf("row%0d_s", i), 70'(sbus()), 70'(vq[i].s));
            chk($sformatf("row%0d_r0", i), 70'(r0bus()), 70'(vq[i].r0));
            chk($sformatf("row%0d_r1", i), 70'(r1bus()), 70'(vq[i].r1));
        end

        // timeout: no s_valid ever
        @(negedge clk);
        set_s(0, 0);
        set_m0(rd(32'h300));
        n   = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (m0_bus.valid) begin
                got = 1;
                break;
            end
            if (s_bus.en) n++;
        end
        set_m0(NR);
        chk("to_done", 70'(got), 70'(1));
        chk("to_busy_cycles", 70'(n), 70'(TO));
        chk("to_r0", 70'(r0bus()), 70'(rs(1, 1, 0)));
        chk("to_m1_valid", 70'(m1_bus.valid), 70'(0));
        @(negedge clk);
        #1;
        chk("to_idle_s", 70'(sbus()), 70'(NR));
        chk("to_idle_r0", 70'(r0bus()), 70'(NZ));

        // s_valid on the timeout edge wins
        @(negedge clk);
        set_m1(rd(32'h400));
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            if (i == TO - 1) set_s(1, 32'h55AA_1234);
            #1;
            chk($sformatf("co_busy%0d", i), 70'(s_bus.en), 70'(1));
        end
        @(negedge clk);
        set_s(0, 0);
        set_m1(NR);
        #1;
        chk("co_r1", 70'(r1bus()), 70'(rs(1, 0, 32'h55AA_1234)));
        chk("co_m0_valid", 70'(m0_bus.valid), 70'(0));

        // master drops en mid-BUSY; response still issued
        @(negedge clk);
        set_m0(rd(32'h500));
        @(negedge clk);
        set_m0(NR);
        #1;
        chk("drop_busy", 70'(s_bus.en), 70'(1));
        @(negedge clk);
        set_s(1, 32'h77);
        #1;
        chk("drop_busy2", 70'(s_bus.en), 70'(1));
        @(negedge clk);
        set_s(0, 0);
        #1;
        chk("drop_r0", 70'(r0bus()), 70'(rs(1, 0, 32'h77)));

        // reset mid-BUSY of m1: no pulse, next tie to m0
        @(negedge clk);
        set_m1(rd(32'h600));
        @(negedge clk);
        #1;
        chk("rb_busy_addr", 70'(s_bus.addr), 70'(32'h600));
        res = 1'b0;
        @(negedge clk);
        #1;
        chk("rb_s", 70'(sbus()), 70'(NR));
        chk("rb_r0", 70'(r0bus()), 70'(NZ));
        chk("rb_r1", 70'(r1bus()), 70'(NZ));
        res = 1'b1;
        set_m0(rd(32'h700));
        @(negedge clk);
        #1;
        chk("rb_tie_s", 70'(sbus()), 70'(rd(32'h700)));
        set_s(1, 32'hBEEF_0007);
        @(negedge clk);
        set_s(0, 0);
        set_m0(NR);
        set_m1(NR);
        #1;
        chk("rb_tie_r0", 70'(r0bus()), 70'(rs(1, 0, 32'hBEEF_0007)));
        chk("rb_tie_r1", 70'(r1bus()), 70'(NZ));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
